cc_position_ctrl: RTL and testbench
===================================

# cc_position_ctrl

Sequencing controller for the position/blank output multiplexer of the game display path. It owns the player position as a one-hot row vector and drives the mux select: show the position or show blank. It handles left/right moves with wrap-around and runs a timed blink sequence after a hit. It sits between the button/timebase logic and the position mux, whose inputs it feeds directly.

## Interface
- POSCTRL_POSWIDTH, 8: width of the one-hot position vector.
- POSCTRL_BLINKDIV, 4: tick strobes per blink half-period (≥1).
- POSCTRL_BLINKCOUNT, 3: blank/show pairs per blink sequence (≥1).

- CC_POSCTRL_CLOCK_50  in  1  system clock; all state updates on its rising edge.
- CC_POSCTRL_RESET_InLow  in  1  asynchronous, active-low reset.
- CC_POSCTRL_tick_In  in  1  one-cycle timebase strobe used for blink timing.
- CC_POSCTRL_start_In  in  1  one-cycle strobe; leaves IDLE.
- CC_POSCTRL_stop_In  in  1  one-cycle strobe; returns to IDLE from any state.
- CC_POSCTRL_left_In  in  1  one-cycle move-left strobe.
- CC_POSCTRL_right_In  in  1  one-cycle move-right strobe.
- CC_POSCTRL_hit_In  in  1  one-cycle collision strobe.
- CC_POSCTRL_select_Out  out  1  mux select: 0 = position, 1 = blank.
- CC_POSCTRL_ubicacion_OutBUS  out  POSWIDTH  one-hot position to the mux.
- CC_POSCTRL_busy_Out  out  1  high while in BLINK.
- CC_POSCTRL_done_Out  out  1  one-cycle pulse when a blink sequence completes.

## Operation
- States: IDLE, RUN, BLINK. All outputs are registered.
- Reset (asynchronous, at any time, including mid-blink) applies immediately:
  - state = IDLE, ubicacion = 1 (bit 0), select = 1, busy = 0, done = 0.
  - tick counter and half-period counter are cleared.
- stop has the highest priority. In any state it gives next state IDLE, select = 1 and busy = 0. Position is held.
- IDLE:
  - select = 1.
  - start gives RUN with ubicacion reloaded to 1 and select = 0.
  - left, right and hit are ignored.
- RUN: select = 0, busy = 0.
  - hit has priority over moves. It gives BLINK, select = 1, busy = 1, and clears both counters. Moves in that cycle are discarded.
  - left alone: rotate left. Bit i goes to i+1, and bit POSWIDTH-1 wraps to bit 0.
  - right alone: rotate right. Bit i goes to i-1, and bit 0 wraps to bit POSWIDTH-1.
  - left and right in the same cycle: no move.
  - start is ignored.
- BLINK: moves, hit and start are ignored.
  - Tick counter (clog2(BLINKDIV) bits) increments on each tick.
  - On the BLINKDIV-th tick: the tick counter clears and the half-period counter hp (clog2(2·BLINKCOUNT) bits) increments.
  - select = ~hp[0]: even hp shows blank, odd hp shows the position.
  - At the end of half-period hp = 2·BLINKCOUNT−1: next state RUN, select = 0, busy = 0, done = 1 for exactly one cycle.
- The position vector is always one-hot outside reset. No state ever produces zero or multi-hot.

## Timing
- Every strobe is sampled on a rising edge. The response appears on the outputs at the same edge, i.e. one cycle of latency.
- BLINK duration = 2·BLINKCOUNT·BLINKDIV ticks. With the defaults that is 24 ticks: 12 ticks blank and 12 ticks shown, alternating every 4 ticks.
- done coincides with the first RUN cycle.
- When stop is asserted during BLINK, done is not generated.
- A tick in the same cycle as hit is not counted. Counting starts with the first tick after entry to BLINK.

## Test plan
- Reset then release, start → first cycle after start: select = 0, ubicacion = 8'h01. Before start: select = 1, ubicacion = 8'h01.
- RUN at 8'h80, left → 8'h01. At 8'h01, right → 8'h80. left and right together at 8'h10 → stays 8'h10.
- RUN at 8'h04, hit plus left in the same cycle → BLINK with ubicacion = 8'h04 and select = 1. Then tick every 3 clocks: select toggles after every 4 ticks in the pattern 1,0,1,0,1,0. After the 24th tick: RUN, select = 0, done high for one cycle, busy low.
- During BLINK: left, right, hit and start pulses → no effect on ubicacion, hp or busy.
- Mid-BLINK (hp = 2), assert reset → outputs go immediately to select = 1, ubicacion = 8'h01, busy = 0, done = 0. After release the state is IDLE.
- Mid-BLINK, stop → IDLE with select = 1, busy = 0, no done pulse, ubicacion held. A later start reloads 8'h01.

Source files
------------

// File: rtl/cc_position_ctrl.sv
// Position/blank mux controller: owns the one-hot player position, handles
// wrap-around moves and runs a tick-timed blink sequence after a hit.
module cc_position_ctrl #(
  parameter int POSCTRL_POSWIDTH   = 8,
  parameter int POSCTRL_BLINKDIV   = 4,
  parameter int POSCTRL_BLINKCOUNT = 3
) (
  input  logic                        CC_POSCTRL_CLOCK_50,
  input  logic                        CC_POSCTRL_RESET_InLow,
  input  logic                        CC_POSCTRL_tick_In,
  input  logic                        CC_POSCTRL_start_In,
  input  logic                        CC_POSCTRL_stop_In,
  input  logic                        CC_POSCTRL_left_In,
  input  logic                        CC_POSCTRL_right_In,
  input  logic                        CC_POSCTRL_hit_In,
  output logic                        CC_POSCTRL_select_Out,
  output logic [POSCTRL_POSWIDTH-1:0] CC_POSCTRL_ubicacion_OutBUS,
  output logic                        CC_POSCTRL_busy_Out,
  output logic                        CC_POSCTRL_done_Out
);

  localparam int W  = POSCTRL_POSWIDTH;
  localparam int TW = (POSCTRL_BLINKDIV > 1) ? $clog2(POSCTRL_BLINKDIV) : 1;
  localparam int HW = $clog2(2 * POSCTRL_BLINKCOUNT);
  localparam logic [TW-1:0] TICK_LAST = TW'(POSCTRL_BLINKDIV - 1);
  localparam logic [HW-1:0] HP_LAST   = HW'(2 * POSCTRL_BLINKCOUNT - 1);
  localparam logic [W-1:0]  POS_HOME  = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BLINK = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  pos_q, pos_d;
  logic          sel_q, sel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [HW-1:0] hp_q, hp_d;

  // Next-state, position, counters and registered output values.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tick_cnt_d = tick_cnt_q;
    hp_d       = hp_q;

    if (CC_POSCTRL_stop_In) begin
      state_d    = ST_IDLE;
      sel_d      = 1'b1;
      busy_d     = 1'b0;
      tick_cnt_d = '0;
      hp_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sel_d  = 1'b1;
          busy_d = 1'b0;
          if (CC_POSCTRL_start_In) begin
            state_d = ST_RUN;
            pos_d   = POS_HOME;
            sel_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          sel_d  = 1'b0;
          busy_d = 1'b0;
          if (CC_POSCTRL_hit_In) begin
            state_d    = ST_BLINK;
            sel_d      = 1'b1;
            busy_d     = 1'b1;
            tick_cnt_d = '0;
            hp_d       = '0;
          end else if (CC_POSCTRL_left_In && !CC_POSCTRL_right_In) begin
            pos_d = {pos_q[W-2:0], pos_q[W-1]};
          end else if (CC_POSCTRL_right_In && !CC_POSCTRL_left_In) begin
            pos_d = {pos_q[0], pos_q[W-1:1]};
          end else begin
            pos_d = pos_q;
          end
        end
        ST_BLINK: begin
          busy_d = 1'b1;
          if (CC_POSCTRL_tick_In) begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_d = '0;
              // The last half-period ends the sequence instead of wrapping hp.
              if (hp_q == HP_LAST) begin
                state_d = ST_RUN;
                sel_d   = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                hp_d    = '0;
              end else begin
                hp_d  = hp_q + HW'(1);
                sel_d = ~hp_d[0];
              end
            end else begin
              tick_cnt_d = tick_cnt_q + TW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          pos_d      = POS_HOME;
          sel_d      = 1'b1;
          busy_d     = 1'b0;
          tick_cnt_d = '0;
          hp_d       = '0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CC_POSCTRL_CLOCK_50 or negedge CC_POSCTRL_RESET_InLow) begin
    if (!CC_POSCTRL_RESET_InLow) begin
      state_q    <= ST_IDLE;
      pos_q      <= POS_HOME;
      sel_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tick_cnt_q <= '0;
      hp_q       <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tick_cnt_q <= tick_cnt_d;
      hp_q       <= hp_d;
    end
  end

  assign CC_POSCTRL_select_Out       = sel_q;
  assign CC_POSCTRL_ubicacion_OutBUS = pos_q;
  assign CC_POSCTRL_busy_Out         = busy_q;
  assign CC_POSCTRL_done_Out         = done_q;

endmodule

// File: tb/tb_cc_position_ctrl.sv
// Self-checking bench for cc_position_ctrl: directed scenarios plus random
// strobes, compared against a mode/index/tick-count reference model.
module tb_cc_position_ctrl;

  localparam int W  = 8;
  localparam int BD = 4;
  localparam int BC = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic tick, start, stop, left, right, hit;
  logic select_o, busy_o, done_o;
  logic [W-1:0] ubic_o;

  int checks = 0;
  int failures = 0;

  // Reference model: 0 = idle, 1 = run, 2 = blink
  int m_mode;
  int m_idx;
  int m_ticks;
  bit m_done;

  always #5 clk = ~clk;

  cc_position_ctrl #(
    .POSCTRL_POSWIDTH(W), .POSCTRL_BLINKDIV(BD), .POSCTRL_BLINKCOUNT(BC)
  ) dut (
    .CC_POSCTRL_CLOCK_50(clk),
    .CC_POSCTRL_RESET_InLow(rst_n),
    .CC_POSCTRL_tick_In(tick),
    .CC_POSCTRL_start_In(start),
    .CC_POSCTRL_stop_In(stop),
    .CC_POSCTRL_left_In(left),
    .CC_POSCTRL_right_In(right),
    .CC_POSCTRL_hit_In(hit),
    .CC_POSCTRL_select_Out(select_o),
    .CC_POSCTRL_ubicacion_OutBUS(ubic_o),
    .CC_POSCTRL_busy_Out(busy_o),
    .CC_POSCTRL_done_Out(done_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_ticks = 0; m_done = 1'b0;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (stop) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_idx = 0; end
    end else if (m_mode == 1) begin
      if (hit) begin
        m_mode = 2; m_ticks = 0;
      end else if (left && !right) begin
        m_idx = (m_idx + 1) % W;
      end else if (right && !left) begin
        m_idx = (m_idx + W - 1) % W;
      end
    end else begin
      if (tick) begin
        m_ticks++;
        if (m_ticks == 2 * BC * BD) begin m_mode = 1; m_done = 1'b1; end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic exp_sel;
    if (m_mode == 0)      exp_sel = 1'b1;
    else if (m_mode == 1) exp_sel = 1'b0;
    else                  exp_sel = ((m_ticks / BD) % 2) == 0;
    check_eq({tag, ".sel"},  {31'd0, select_o}, {31'd0, exp_sel});
    check_eq({tag, ".pos"},  {24'd0, ubic_o}, 32'd1 << m_idx);
    check_eq({tag, ".busy"}, {31'd0, busy_o}, {31'd0, m_mode == 2});
    check_eq({tag, ".done"}, {31'd0, done_o}, {31'd0, m_done});
  endtask

  task automatic cyc(input string tag, input logic st, input logic sp, input logic l,
                     input logic r, input logic h, input logic t);
    start = st; stop = sp; left = l; right = r; hit = h; tick = t;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    {tick, start, stop, left, right, hit} = 6'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    cyc("idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc("idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("pre_start.pos", {24'd0, ubic_o}, 32'h01);
    cyc("start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("start.sel", {31'd0, select_o}, 32'd0);
    cyc("wrap_r", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("wrap_r.pos", {24'd0, ubic_o}, 32'h80);
    cyc("wrap_l", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("wrap_l.pos", {24'd0, ubic_o}, 32'h01);
    for (int i = 0; i < 4; i++) cyc("mv_l", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lr_both", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("lr_both.pos", {24'd0, ubic_o}, 32'h10);
    cyc("mv_r", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("mv_r", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("hit_left", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("hit.pos", {24'd0, ubic_o}, 32'h04);
    check_eq("hit.sel", {31'd0, select_o}, 32'd1);

    // Full blink: tick every third clock, stray strobes on idle clocks.
    for (int k = 0; k < 2 * BC * BD; k++) begin
      cyc("blk_a", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc("blk_b", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("blk_t", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check_eq("blink_end.done", {31'd0, done_o}, 32'd1);
    cyc("after_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("after_done.done", {31'd0, done_o}, 32'd0);

    // Stop mid-blink, then restart.
    cyc("hit2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) cyc("blk2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("stop", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("stop.pos", {24'd0, ubic_o}, 32'h04);
    for (int k = 0; k < 30; k++) cyc("idle_t", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("restart.pos", {24'd0, ubic_o}, 32'h01);

    // Asynchronous reset in the middle of hp = 2.
    cyc("hit3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) cyc("blk3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    {tick, start, stop, left, right, hit} = 6'd0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Random strobes.
    for (int n = 0; n < 3000; n++) begin
      cyc("rand",
          $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 50);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
